entity_step_scheduler: RTL and testbench
========================================

Name: entity_step_scheduler

Overview:
Per-frame sequencer that shares the single maze-wall ROM read port between Pacman and the ghosts. On each frame tick during the Level state, it visits each entity in fixed index order. For each eligible entity it presents that entity's next-cell address to the ROM, waits the ROM latency, then pulses that entity's step enable together with the wall result. It sits between the top-level game-state controller (2-bit state code) and the per-entity movement registers.

Parameters:
N_ENT, 5, entity count; index 0 = Pacman, 1..N_ENT-1 = ghosts
ADDR_W, 10, maze ROM address width
ROM_LAT, 2, ROM read latency in cycles (>=1)
GHOST_DIV, 2, ghosts move once every GHOST_DIV accepted frames (>=1)

Ports:
Clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
game_state  in  2  00 Start, 01 Level, 10 GameOver, 11 YouWin
ent_addr  in  N_ENT*ADDR_W  next-cell address; entity i at [i*ADDR_W +: ADDR_W]
maze_addr  out  ADDR_W  ROM address, registered
maze_wall  in  1  ROM data: 1 = wall; valid ROM_LAT cycles after maze_addr changes
step_en  out  N_ENT  one-hot, one-cycle pulse: entity i may update its position
step_blocked  out  1  wall result; meaningful only while step_en != 0
busy  out  1  high whenever FSM is not IDLE
overrun  out  1  sticky; a frame_tick arrived while busy

Behaviour:
- Reset (async): FSM=IDLE, idx=0, frame_mod=0, maze_addr=0, step_en=0, step_blocked=0, overrun=0.
- FSM states: IDLE, ISSUE, WAIT, COMMIT.
- IDLE:
  - frame_tick && game_state==01 → ISSUE next cycle.
  - On that transition: idx=0; ghost_ok = (frame_mod==0); frame_mod = (frame_mod+1) mod GHOST_DIV.
  - frame_tick in any other game_state is ignored.
- ISSUE (1 cycle):
  - eligible = (idx==0) || ghost_ok.
  - If eligible: register maze_addr ← ent_addr[idx]; load wait_cnt=ROM_LAT-1; go WAIT.
  - If not eligible: go IDLE if idx==N_ENT-1, else idx++ and stay in ISSUE.
- WAIT: exactly ROM_LAT cycles; decrement wait_cnt; at 0 go COMMIT. maze_addr is held stable through COMMIT.
- COMMIT (1 cycle):
  - step_en[idx]=1; step_blocked = maze_wall (combinational pass-through, gated by COMMIT).
  - Then go IDLE if idx==N_ENT-1, else idx++ and go ISSUE.
- Per eligible entity cost: ROM_LAT+2 cycles. Per skipped entity cost: 1 cycle.
- step_en is 0 in every state except COMMIT. step_blocked=0 outside COMMIT.
- frame_tick while FSM != IDLE: tick dropped, frame_mod unchanged, overrun←1. overrun is cleared only by reset.
- game_state != 01 while FSM != IDLE: abort to IDLE on the next edge. No step_en in the abort cycle or after. Takes priority over COMMIT in the same cycle.
- game_state==00 (Start) in any FSM state: frame_mod←0, so the first frame of every level moves the ghosts.
- ent_addr is sampled only in ISSUE. Later changes do not affect the in-flight lookup.
- GHOST_DIV==1: ghosts are eligible every frame.

Decomposition:
- game_pkg holds:
  - game_state_t enum (START=2'b00, LEVEL=2'b01, GAMEOVER=2'b10, YOUWIN=2'b11), shared with the top-level game controller.
  - sched_state_t enum (IDLE, ISSUE, WAIT, COMMIT).
  - Localparam ENT_PACMAN=0.
- One natural sub-module: frame_divider (mod-GHOST_DIV counter with sync clear and an advance strobe; outputs the at-zero flag).

Test Plan:
- Ghost frame: reset; game_state=01; frame_tick at cycle 0 → step_en = 00001 @4, 00010 @8, 00100 @12, 01000 @16, 10000 @20; busy low @21; maze_addr = ent_addr[i] from ISSUE+1 through COMMIT.
- Skip frame: second tick after first completes → step_en=00001 @4 only; idx 1..4 skipped @5..8; busy low @9. Third tick → ghosts move again.
- Wall result: ROM model returns maze_wall=1 only for entity 2's address → step_blocked=1 only during step_en=00100; 0 for the other pulses.
- Overrun: frame_tick at cycle 0 and cycle 10 → overrun=1 from cycle 11 and stays high; frame_mod unchanged; frame completes normally @20.
- Abort: game_state 01→10 at cycle 6 → FSM IDLE @7; no further step_en; subsequent ticks ignored. Then game_state=00 and back to 01 → next frame moves all 5 entities.
- Async reset mid-WAIT: assert reset between edges → outputs zero immediately; busy=0; no step_en after deassertion until the next valid tick.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-level types.
//   game_state_t  : 2-bit state code driven by the top-level game controller.
//   sched_state_t : step scheduler FSM encoding, also exported on its debug port.
//   ENT_PACMAN    : entity index of Pacman; every other index is a ghost.
package game_pkg;

  typedef enum logic [1:0] {
    START    = 2'b00,
    LEVEL    = 2'b01,
    GAMEOVER = 2'b10,
    YOUWIN   = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    WAIT   = 2'b10,
    COMMIT = 2'b11
  } sched_state_t;

  localparam int ENT_PACMAN = 0;

endpackage

// File: rtl/frame_divider.sv
// Modulo-DIV frame counter deciding which accepted frames move the ghosts.
// Ports:
//   Clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous return to zero (wins over advance)
//   advance    : one-cycle strobe, step the counter by one (wrapping at DIV)
//   at_zero    : counter currently reads zero
// With DIV==1 the counter never leaves zero, so at_zero is constantly high.
module frame_divider #(
  parameter int DIV = 2
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic at_zero
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      if (cnt == CW'(DIV - 1)) cnt <= '0;
      else                     cnt <= cnt + CW'(1);
    end
  end

  assign at_zero = (cnt == '0);

endmodule

// File: rtl/entity_step_scheduler.sv
// Per-frame sequencer sharing the maze-wall ROM read port between Pacman and
// the ghosts. On an accepted frame tick it walks the entities in index order;
// each eligible entity gets its next-cell address put on the ROM, a ROM_LAT
// cycle wait, and then a one-cycle step_en pulse carrying the wall result.
// Ports:
//   Clk, reset   : clock, asynchronous active-high reset
//   frame_tick   : one-cycle pulse per video frame
//   game_state   : 00 Start, 01 Level, 10 GameOver, 11 YouWin
//   ent_addr     : packed next-cell addresses, entity i at [i*ADDR_W +: ADDR_W]
//   maze_addr    : registered ROM address
//   maze_wall    : ROM data (1 = wall), valid ROM_LAT cycles after maze_addr
//   step_en      : one-hot pulse, entity i may update its position
//   step_blocked : wall result for the pulsing entity, 0 when step_en == 0
//   busy         : FSM not IDLE
//   overrun      : sticky, a frame tick was dropped because the FSM was busy
//   dbg_state    : current FSM state
// Output qualifier: step_blocked carries information only in the cycle where
// step_en is non-zero; consumers must treat it as don't-care otherwise (it is
// driven to 0 there anyway).
module entity_step_scheduler
  import game_pkg::*;
#(
  parameter int N_ENT     = 5,
  parameter int ADDR_W    = 10,
  parameter int ROM_LAT   = 2,
  parameter int GHOST_DIV = 2
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [1:0]              game_state,
  input  logic [N_ENT*ADDR_W-1:0] ent_addr,
  output logic [ADDR_W-1:0]       maze_addr,
  input  logic                    maze_wall,
  output logic [N_ENT-1:0]        step_en,
  output logic                    step_blocked,
  output logic                    busy,
  output logic                    overrun,
  output sched_state_t            dbg_state
);

  localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  sched_state_t      state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              ghost_ok, ghost_ok_nxt;
  logic [ADDR_W-1:0] maze_addr_nxt;
  logic              accept;
  logic              at_zero;
  logic              in_level;
  logic              in_start;
  logic              last_ent;
  logic              eligible;
  game_state_t       gs;

  assign gs       = game_state_t'(game_state);
  assign in_level = (gs == LEVEL);
  assign in_start = (gs == START);
  assign last_ent = (idx == IDX_W'(N_ENT - 1));
  assign eligible = (idx == IDX_W'(ENT_PACMAN)) || ghost_ok;

  // Start clears the divider so the first frame of every level moves ghosts.
  frame_divider #(
    .DIV (GHOST_DIV)
  ) u_frame_divider (
    .Clk     (Clk),
    .reset   (reset),
    .clear   (in_start),
    .advance (accept),
    .at_zero (at_zero)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      ghost_ok  <= 1'b0;
      maze_addr <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      wait_cnt  <= wait_cnt_nxt;
      ghost_ok  <= ghost_ok_nxt;
      maze_addr <= maze_addr_nxt;
    end
  end

  // Any tick seen while a frame is still in flight is dropped and flagged.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (frame_tick && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    wait_cnt_nxt  = wait_cnt;
    ghost_ok_nxt  = ghost_ok;
    maze_addr_nxt = maze_addr;
    accept        = 1'b0;
    step_en       = '0;
    step_blocked  = 1'b0;

    case (state)
      IDLE: begin
        if (frame_tick && in_level) begin
          accept       = 1'b1;
          idx_nxt      = '0;
          ghost_ok_nxt = at_zero;
          state_nxt    = ISSUE;
        end
      end

      ISSUE: begin
        if (!in_level) begin
          state_nxt = IDLE;
        end else if (eligible) begin
          maze_addr_nxt = ent_addr[idx*ADDR_W +: ADDR_W];
          wait_cnt_nxt  = CNT_W'(ROM_LAT - 1);
          state_nxt     = WAIT;
        end else if (last_ent) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end

      WAIT: begin
        if (!in_level) begin
          state_nxt = IDLE;
        end else if (wait_cnt == '0) begin
          state_nxt = COMMIT;
        end else begin
          wait_cnt_nxt = wait_cnt - CNT_W'(1);
        end
      end

      COMMIT: begin
        // Leaving Level in this very cycle suppresses the pulse.
        if (!in_level) begin
          state_nxt = IDLE;
        end else begin
          step_en      = N_ENT'(1) << idx;
          step_blocked = maze_wall;
          if (last_ent) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = ISSUE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_entity_step_scheduler.sv
// Directed bench for entity_step_scheduler (N_ENT=5, ADDR_W=10, ROM_LAT=2,
// GHOST_DIV=2). Cycle 0 of a frame is the cycle in which frame_tick is high.
module tb_entity_step_scheduler;
  import game_pkg::*;

  localparam int N_ENT  = 5;
  localparam int ADDR_W = 10;

  logic                    Clk;
  logic                    reset;
  logic                    frame_tick;
  logic [1:0]              game_state;
  logic [N_ENT*ADDR_W-1:0] ent_addr;
  logic [ADDR_W-1:0]       maze_addr;
  logic                    maze_wall;
  logic [N_ENT-1:0]        step_en;
  logic                    step_blocked;
  logic                    busy;
  logic                    overrun;
  sched_state_t            dbg_state;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] addr_tab [N_ENT];
  logic              rom_q1, rom_q2;

  entity_step_scheduler #(
    .N_ENT     (N_ENT),
    .ADDR_W    (ADDR_W),
    .ROM_LAT   (2),
    .GHOST_DIV (2)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .game_state   (game_state),
    .ent_addr     (ent_addr),
    .maze_addr    (maze_addr),
    .maze_wall    (maze_wall),
    .step_en      (step_en),
    .step_blocked (step_blocked),
    .busy         (busy),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Two-cycle ROM: only entity 2's cell is a wall.
  always @(posedge Clk) begin
    rom_q1 <= (maze_addr == addr_tab[2]);
    rom_q2 <= rom_q1;
  end
  assign maze_wall = rom_q2;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [N_ENT*ADDR_W-1:0] pack_addr(input bit garble);
    logic [N_ENT*ADDR_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_ENT; i++)
      v[i*ADDR_W +: ADDR_W] = (garble && i == 0) ? {ADDR_W{1'b1}} : addr_tab[i];
    return v;
  endfunction

  // One frame, cycles 0..24. ghosts: frame moves ghosts (else skip frame).
  // abort_at: cycle where game_state goes GameOver (-1 none).
  // tick2_at: cycle of an extra, overrunning tick (-1 none).
  // Entity 0's address is corrupted during cycles 2..4, after it was sampled.
  task automatic run_frame(input bit ghosts, input int abort_at, input int tick2_at,
                           input bit ovr_start);
    int last_c, end_c;
    logic [N_ENT-1:0]  se_exp;
    logic [ADDR_W-1:0] a_exp;
    last_c = ghosts ? 20 : 8;
    end_c  = (abort_at >= 0) ? abort_at : last_c;
    for (int c = 0; c <= 24; c++) begin
      frame_tick = (c == 0) || (c == tick2_at);
      game_state = (abort_at >= 0 && c >= abort_at) ? GAMEOVER : LEVEL;
      ent_addr   = pack_addr(c >= 2 && c <= 4);
      @(negedge Clk);
      se_exp = '0;
      if (ghosts && c >= 4 && c <= 20 && (c % 4) == 0) se_exp = N_ENT'(1) << (c / 4 - 1);
      if (!ghosts && c == 4) se_exp = 5'b00001;
      if (abort_at >= 0 && c >= abort_at) se_exp = '0;
      chk($sformatf("step_en c%0d", c), 32'(step_en), 32'(se_exp));
      chk($sformatf("step_blocked c%0d", c), 32'(step_blocked), 32'(se_exp == 5'b00100));
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= end_c));
      chk($sformatf("overrun c%0d", c), 32'(overrun),
          32'(ovr_start || (tick2_at >= 0 && c > tick2_at)));
      if (c >= 2 && c <= end_c && (abort_at < 0 || c < abort_at)) begin
        a_exp = ghosts ? addr_tab[(c - 2) / 4] : addr_tab[0];
        chk($sformatf("maze_addr c%0d", c), 32'(maze_addr), 32'(a_exp));
      end
      if (c == 1) chk("dbg_state issue", 32'(dbg_state), 32'(ISSUE));
      next_cycle();
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N_ENT; i++) addr_tab[i] = ADDR_W'(16'h040 + i * 16'h05B);
    reset      = 1'b1;
    frame_tick = 1'b0;
    game_state = START;
    ent_addr   = pack_addr(1'b0);
    #1;
    chk("reset step_en", 32'(step_en), 32'd0);
    chk("reset maze_addr", 32'(maze_addr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    chk("reset step_blocked", 32'(step_blocked), 32'd0);
    chk("reset dbg_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b0;
    next_cycle();

    // Ghost frame with an overrunning tick at cycle 10.
    run_frame(1'b1, -1, 10, 1'b0);
    // Dropped tick left frame_mod alone: skip frame, then ghosts again.
    run_frame(1'b0, -1, -1, 1'b1);
    run_frame(1'b1, -1, -1, 1'b1);

    // Start clears the divider; then abort exactly on entity 1's commit.
    game_state = START;
    next_cycle();
    next_cycle();
    run_frame(1'b1, 8, -1, 1'b1);

    // Ticks outside Level are ignored.
    frame_tick = 1'b1;
    game_state = GAMEOVER;
    next_cycle();
    frame_tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk($sformatf("gameover busy k%0d", k), 32'(busy), 32'd0);
      chk($sformatf("gameover step_en k%0d", k), 32'(step_en), 32'd0);
      next_cycle();
    end

    // Back through Start: divider was at 1, cleared, so ghosts move.
    game_state = START;
    next_cycle();
    next_cycle();
    run_frame(1'b1, -1, -1, 1'b1);

    // Asynchronous reset in the middle of WAIT.
    frame_tick = 1'b1;
    game_state = LEVEL;
    next_cycle();
    frame_tick = 1'b0;
    next_cycle();
    @(negedge Clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async busy", 32'(busy), 32'd0);
    chk("async step_en", 32'(step_en), 32'd0);
    chk("async maze_addr", 32'(maze_addr), 32'd0);
    chk("async overrun", 32'(overrun), 32'd0);
    chk("async step_blocked", 32'(step_blocked), 32'd0);
    chk("async dbg_state", 32'(dbg_state), 32'(IDLE));
    @(posedge Clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      chk($sformatf("post-reset busy k%0d", k), 32'(busy), 32'd0);
      chk($sformatf("post-reset step_en k%0d", k), 32'(step_en), 32'd0);
      next_cycle();
    end
    // Divider reset to zero: next frame moves all entities.
    run_frame(1'b1, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
